// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write, reserve, clear and read-port signals.
// The master drives requests; the slave (register file) returns read data and status.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     clr_req;
    logic                     clr_busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clr_req,
        input  rd_data, rd_busy, clr_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr, clr_req,
        output rd_data, rd_busy, clr_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a per-entry busy scoreboard, write bypass and a sequential bulk clear.
// Handshake: wr_en, rsv_en and clr_req are one-cycle requests with no ready; clr_busy high means requests are dropped.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_sb_if.slave bus,
    output logic        state_dbg
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    busy;
    logic                wr_acc;
    logic                rsv_acc;

    assign wr_acc  = bus.wr_en && (state == IDLE) &&
                     !((ZERO_REG != 0) && (bus.wr_addr == '0));
    assign rsv_acc = bus.rsv_en && (state == IDLE) &&
                     !((ZERO_REG != 0) && (bus.rsv_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_cnt <= '0;
            busy    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_acc) begin
                        mem[bus.wr_addr]  <= bus.wr_data;
                        busy[bus.wr_addr] <= 1'b0;
                    end
                    // Placed after the write so a same-address reservation wins.
                    if (rsv_acc) begin
                        busy[bus.rsv_addr] <= 1'b1;
                    end
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    mem[clr_cnt]  <= '0;
                    busy[clr_cnt] <= 1'b0;
                    clr_cnt       <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] a;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        a           = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = bus.rd_addr[i*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (a == '0)) begin
                bus.rd_data[i*DATA_W +: DATA_W] = '0;
                bus.rd_busy[i]                  = 1'b0;
            end else if ((BYPASS != 0) && wr_acc && (bus.wr_addr == a)) begin
                bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data;
                bus.rd_busy[i]                  = 1'b0;
            end else begin
                bus.rd_data[i*DATA_W +: DATA_W] = mem[a];
                bus.rd_busy[i]                  = busy[a];
            end
            // During a bulk clear every operand is treated as pending.
            if (state == CLEAR) begin
                bus.rd_busy[i] = 1'b1;
            end
        end
    end

    assign bus.clr_busy = (state == CLEAR);
    assign state_dbg    = (state == CLEAR);
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, entry width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2^ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..8).
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = entry 0 hardwired to zero, never busy.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-010 SHALL have port wr_data  input  DATA_W  write data.
REQ-011 SHALL have port rd_addr  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rd_data  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W].
REQ-013 SHALL have port rd_busy  output  NUM_RD  per-port pending-write (hazard) flag.
REQ-014 SHALL have port rsv_en  input  1  reserve destination (mark busy).
REQ-015 SHALL have port rsv_addr  input  ADDR_W  address to reserve.
REQ-016 SHALL have port clr_req  input  1  start bulk clear of all entries.
REQ-017 SHALL have port clr_busy  output  1  bulk clear in progress.

Function
REQ-018 SHALL hold DEPTH entries of DATA_W bits plus one busy bit per entry.
REQ-019 SHALL accept a write when wr_en=1, state IDLE, and not (ZERO_REG=1 and wr_addr=0); entry updated at next rising edge.
REQ-020 SHALL clear busy[wr_addr] on an accepted write.
REQ-021 SHALL set busy[rsv_addr] on next edge when rsv_en=1, state IDLE, and not (ZERO_REG=1 and rsv_addr=0).
REQ-022 SHALL give the set priority when rsv_en and accepted write target the same address in the same cycle (busy=1 after edge, data updated).
REQ-023 SHALL drive rd_data combinationally (zero-cycle latency) from the addressed entry.
REQ-024 SHALL, when BYPASS=1 and an accepted write's wr_addr equals rd_addr of port i, drive wr_data on that port in the same cycle.
REQ-025 SHALL drive rd_data port i to 0 when ZERO_REG=1 and its rd_addr=0, regardless of writes.
REQ-026 SHALL drive rd_busy[i] = busy[rd_addr_i], forced 0 when BYPASS=1 and an accepted write hits that address, forced 0 for address 0 when ZERO_REG=1.
REQ-027 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1; CLEAR->IDLE after the entry DEPTH-1 clear cycle.
REQ-028 SHALL, in CLEAR, zero one entry and its busy bit per cycle using an ADDR_W-bit counter running 0..DEPTH-1.
REQ-029 SHALL assert clr_busy exactly for the DEPTH cycles following the clr_req edge; clr_req at edge n gives clr_busy high in cycles n+1..n+DEPTH.
REQ-030 SHALL ignore wr_en, rsv_en and clr_req while in CLEAR.
REQ-031 SHALL force all rd_busy bits to 1 while in CLEAR; rd_data returns stored (possibly partially cleared) values.
REQ-032 SHALL let a write and clr_req arriving in the same IDLE cycle both take effect: the write lands first, the clear then overwrites it.

Reset
REQ-033 SHALL, on rst=1 at a rising edge, zero all entries and busy bits, enter IDLE, zero the clear counter.
REQ-034 SHALL give rst priority over all other inputs, including mid-CLEAR, which aborts to IDLE with all state zero.
REQ-035 SHALL drive clr_busy=0, rd_busy=0 and rd_data=0 in the cycle after reset.

Verification
REQ-036 SHALL check write/read: wr_en, addr 5, data 0xDEADBEEF; next cycle rd_addr0=5 -> rd_data0=0xDEADBEEF.
REQ-037 SHALL check zero register: write 0x12345678 to addr 0 with ZERO_REG=1 -> rd_data reads 0, rd_busy 0; rsv_en addr 0 -> no effect.
REQ-038 SHALL check bypass: same cycle wr_en addr 7 data 0xA5A5A5A5 and rd_addr1=7 -> rd_data1=0xA5A5A5A5, rd_busy[1]=0.
REQ-039 SHALL check scoreboard: rsv_en addr 9 -> rd_busy=1 for addr 9 next cycle; write addr 9 -> 0 after edge; simultaneous rsv+write addr 9 -> busy stays 1, data updated.
REQ-040 SHALL check clear: fill entries with nonzero data, pulse clr_req -> clr_busy high exactly 32 cycles (ADDR_W=5), writes ignored during that time, all reads 0 afterwards.
REQ-041 SHALL check reset mid-clear: rst asserted at clear cycle 10 -> clr_busy=0, all entries 0, IDLE next cycle.
